// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller: segment patterns,
// scan FSM states and display geometry.
package seg_pkg;

    localparam int NUM_DIGITS = 8;

    // Active-low {dp,g,f,e,d,c,b,a}; decimal point always off
    localparam logic [7:0] D0 = 8'hC0;
    localparam logic [7:0] D1 = 8'hF9;
    localparam logic [7:0] D2 = 8'hA4;
    localparam logic [7:0] D3 = 8'hB0;
    localparam logic [7:0] D4 = 8'h99;
    localparam logic [7:0] D5 = 8'h92;
    localparam logic [7:0] D6 = 8'h82;
    localparam logic [7:0] D7 = 8'hF8;
    localparam logic [7:0] D8 = 8'h80;
    localparam logic [7:0] D9 = 8'h90;
    localparam logic [7:0] DN = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

endpackage

// File: rtl/seg_digit_decode.sv
// BCD nibble to active-low seven-segment pattern; non-decimal nibbles blank.
import seg_pkg::*;

module seg_digit_decode (
    input  logic [3:0] nib,
    output logic [7:0] seg
);

    // Pure lookup, codes 10..15 fall through to blank
    always_comb begin
        case (nib)
            4'd0:    seg = D0;
            4'd1:    seg = D1;
            4'd2:    seg = D2;
            4'd3:    seg = D3;
            4'd4:    seg = D4;
            4'd5:    seg = D5;
            4'd6:    seg = D6;
            4'd7:    seg = D7;
            4'd8:    seg = D8;
            4'd9:    seg = D9;
            default: seg = DN;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed display scanner with a double-buffered frame that
// only commits at frame boundaries, plus an inter-digit blanking gap.
import seg_pkg::*;

module seg_scan_ctrl #(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_data,
    input  logic [7:0]  load_mask,
    output logic [7:0]  dig,
    output logic [7:0]  bit_ctrl,
    output logic        frame_done
);

    localparam int CNT_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
    localparam logic [2:0]       LAST_IDX = 3'(NUM_DIGITS - 1);

    state_t           state_r;
    logic [2:0]       idx_r;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      act_data_r;
    logic [7:0]       act_mask_r;
    logic [31:0]      pend_data_r;
    logic [7:0]       pend_mask_r;
    logic             pend_full_r;
    logic             wrap_r;
    logic [7:0]       dig_r;
    logic [7:0]       bit_ctrl_r;
    logic             frame_done_r;

    logic             accept_s;
    logic             slot_end_s;
    logic [3:0]       nib_s;
    logic [7:0]       seg_s;
    logic [7:0]       dig_s;
    logic [7:0]       bit_ctrl_s;

    assign load_ready = ~pend_full_r;
    assign accept_s   = load_valid & ~pend_full_r;
    assign nib_s      = act_data_r[{idx_r, 2'b00} +: 4];
    assign dig        = dig_r;
    assign bit_ctrl   = bit_ctrl_r;
    assign frame_done = frame_done_r;

    seg_digit_decode u_decode (
        .nib (nib_s),
        .seg (seg_s)
    );

    // End of a digit slot: after the blank gap, or straight after SHOW when there is no gap
    always_comb begin
        if (state_r == BLANK) begin
            slot_end_s = (cnt_r == BLK_LAST);
        end else if ((state_r == SHOW) && (BLANK_CYCLES == 0)) begin
            slot_end_s = (cnt_r == DIG_LAST);
        end else begin
            slot_end_s = 1'b0;
        end
    end

    // Next output pattern; select and segments both derive from the same idx
    always_comb begin
        dig_s      = DN;
        bit_ctrl_s = 8'hFF;
        if ((state_r == SHOW) && act_mask_r[idx_r]) begin
            dig_s      = seg_s;
            bit_ctrl_s = ~(8'd1 << idx_r);
        end else begin
            dig_s      = DN;
            bit_ctrl_s = 8'hFF;
        end
    end

    // Scan FSM, frame buffers and registered display outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r      <= IDLE;
            idx_r        <= 3'd0;
            cnt_r        <= '0;
            act_data_r   <= 32'd0;
            act_mask_r   <= 8'd0;
            pend_data_r  <= 32'd0;
            pend_mask_r  <= 8'd0;
            pend_full_r  <= 1'b0;
            wrap_r       <= 1'b0;
            dig_r        <= DN;
            bit_ctrl_r   <= 8'hFF;
            frame_done_r <= 1'b0;
        end else begin
            dig_r        <= dig_s;
            bit_ctrl_r   <= bit_ctrl_s;
            frame_done_r <= wrap_r;
            wrap_r       <= 1'b0;

            if (accept_s) begin
                pend_data_r <= load_data;
                pend_mask_r <= load_mask;
                pend_full_r <= 1'b1;
            end

            case (state_r)
                IDLE: begin
                    if (pend_full_r) begin
                        act_data_r  <= pend_data_r;
                        act_mask_r  <= pend_mask_r;
                        pend_full_r <= 1'b0;
                        idx_r       <= 3'd0;
                        cnt_r       <= '0;
                        state_r     <= SHOW;
                    end
                end
                SHOW: begin
                    if (cnt_r == DIG_LAST) begin
                        cnt_r   <= '0;
                        state_r <= (BLANK_CYCLES == 0) ? SHOW : BLANK;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                BLANK: begin
                    if (cnt_r == BLK_LAST) begin
                        cnt_r <= '0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                end
            endcase

            // Slot exit overrides the state step above; commit only at the frame wrap
            if (slot_end_s) begin
                state_r <= SHOW;
                if (idx_r != LAST_IDX) begin
                    idx_r <= idx_r + 3'd1;
                end else begin
                    idx_r  <= 3'd0;
                    wrap_r <= 1'b1;
                    if (pend_full_r) begin
                        act_data_r  <= pend_data_r;
                        act_mask_r  <= pend_mask_r;
                        pend_full_r <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench: one scanner with a one-cycle blank gap and one with no gap,
// sharing clock, reset and the load bus.
module tb_seg_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        load_valid;
    logic [31:0] load_data;
    logic [7:0]  load_mask;
    logic        a_ready, b_ready;
    logic [7:0]  a_dig, b_dig, a_bit, b_bit;
    logic        a_fd, b_fd;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] F1 = 32'h7654_3210;
    localparam logic [7:0]  M1 = 8'hFF;
    localparam logic [31:0] F2 = 32'h8765_4A21;
    localparam logic [7:0]  M2 = 8'b0000_0101;
    localparam logic [31:0] F3 = 32'h0F98_7654;
    localparam logic [7:0]  M3 = 8'b1011_1111;

    seg_scan_ctrl #(.DIGIT_CYCLES(4), .BLANK_CYCLES(1)) dut_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .load_valid(load_valid), .load_ready(a_ready),
        .load_data(load_data), .load_mask(load_mask), .dig(a_dig), .bit_ctrl(a_bit),
        .frame_done(a_fd)
    );

    seg_scan_ctrl #(.DIGIT_CYCLES(4), .BLANK_CYCLES(0)) dut_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .load_valid(load_valid), .load_ready(b_ready),
        .load_data(load_data), .load_mask(load_mask), .dig(b_dig), .bit_ctrl(b_bit),
        .frame_done(b_fd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0: return 8'hC0;
            4'd1: return 8'hF9;
            4'd2: return 8'hA4;
            4'd3: return 8'hB0;
            4'd4: return 8'h99;
            4'd5: return 8'h92;
            4'd6: return 8'h82;
            4'd7: return 8'hF8;
            4'd8: return 8'h80;
            4'd9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic sel, input logic [7:0] ed,
                           input logic [7:0] eb, input logic efd, input logic erdy);
        chk({tag, ".dig"},   sel ? b_dig : a_dig, ed);
        chk({tag, ".bit"},   sel ? b_bit : a_bit, eb);
        chk({tag, ".fd"},    {7'd0, sel ? b_fd : a_fd}, {7'd0, efd});
        chk({tag, ".ready"}, {7'd0, sel ? b_ready : a_ready}, {7'd0, erdy});
    endtask

    // Load into an idle scanner: accept edge, then commit edge with outputs still blank
    task automatic load_idle(input logic sel, input logic [31:0] d, input logic [7:0] m);
        load_valid = 1'b1;
        load_data  = d;
        load_mask  = m;
        tick();
        load_valid = 1'b0;
        chk("accept.ready", {7'd0, sel ? b_ready : a_ready}, 8'd0);
        tick();
        chk_all("commit", sel, 8'hFF, 8'hFF, 1'b0, 1'b1);
    endtask

    // Check nslots digit slots of one frame; optionally swap in the next offer after the first edge
    task automatic scan(input string tag, input logic sel, input logic [31:0] d, input logic [7:0] m,
                        input int bc, input logic fd0, input logic pend, input logic keep,
                        input logic [31:0] nd, input logic [7:0] nm, input int nslots);
        int t;
        int total;
        logic [7:0] ed, eb;
        t = 0;
        total = nslots * (4 + bc);
        for (int k = 0; k < nslots; k++) begin
            for (int c = 0; c < 4 + bc; c++) begin
                tick();
                if (t == 0) begin
                    if (keep) begin
                        load_data = nd;
                        load_mask = nm;
                    end else begin
                        load_valid = 1'b0;
                    end
                end
                if ((c < 4) && m[k]) begin
                    ed = seg_of(d[k*4 +: 4]);
                    eb = ~(8'd1 << k);
                end else begin
                    ed = 8'hFF;
                    eb = 8'hFF;
                end
                chk_all($sformatf("%s.d%0d.c%0d", tag, k, c), sel, ed, eb,
                        (t == 0) && fd0, pend ? (t == total - 1) : 1'b1);
                t++;
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = 32'd0;
        load_mask  = 8'd0;
        repeat (3) tick();
        chk_all("rst.a", 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b1);
        chk_all("rst.b", 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all($sformatf("idle%0d", i), 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b1);
        end

        // Single frame, then a second scan proves a 40-cycle frame_done period
        load_idle(1'b0, F1, M1);
        scan("f1a", 1'b0, F1, M1, 1, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0, 8);
        scan("f1b", 1'b0, F1, M1, 1, 1'b1, 1'b0, 1'b0, 32'd0, 8'd0, 8);

        // Offer F2 mid-display, then keep offering F3 which must stall until F2 commits
        load_valid = 1'b1;
        load_data  = F2;
        load_mask  = M2;
        scan("f1c", 1'b0, F1, M1, 1, 1'b1, 1'b1, 1'b1, F3, M3, 8);
        scan("f2",  1'b0, F2, M2, 1, 1'b1, 1'b1, 1'b0, 32'd0, 8'd0, 8);
        scan("f3",  1'b0, F3, M3, 1, 1'b1, 1'b0, 1'b0, 32'd0, 8'd0, 5);
        tick();
        chk_all("f3.d5.c0", 1'b0, 8'h90, 8'hDF, 1'b0, 1'b1);
        tick();
        chk_all("f3.d5.c1", 1'b0, 8'h90, 8'hDF, 1'b0, 1'b1);

        // Asynchronous reset in the middle of digit 5
        #2 rst_n = 1'b0;
        #1 chk_all("areset", 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b1);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all($sformatf("post_rst.a%0d", i), 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b1);
            chk_all($sformatf("post_rst.b%0d", i), 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1);
        end

        // No-gap variant: back-to-back digits, 32-cycle frame period
        load_idle(1'b1, F1, M1);
        scan("nb_a", 1'b1, F1, M1, 0, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0, 8);
        scan("nb_b", 1'b1, F1, M1, 0, 1'b1, 1'b0, 1'b0, 32'd0, 8'd0, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
